// File: rtl/sigma_filter_stream_if.sv
// Pixel stream bundle for sigma_filter_stream: input handshake, frame config and output strobe.
interface sigma_filter_stream_if #(
    parameter int DW = 10
);
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] cfg_thr;
    logic          cfg_bypass;
    logic [DW-1:0] denoised_data;
    logic          denoised_data_valid;
    logic          denoised_sof;
    logic          denoised_eol;

    // A pixel moves on a rising edge where data_valid & data_ready; the source holds data
    // while data_ready is low. The output side is a strobe with no backpressure.
    modport master (
        output data, data_valid, cfg_thr, cfg_bypass,
        input  data_ready, denoised_data, denoised_data_valid, denoised_sof, denoised_eol
    );
    modport slave (
        input  data, data_valid, cfg_thr, cfg_bypass,
        output data_ready, denoised_data, denoised_data_valid, denoised_sof, denoised_eol
    );
endinterface

// File: rtl/sigma_filter_stream.sv
// Streaming 3x3 edge-preserving (sigma) denoiser with replicate-clamped borders.
// A 2W+2 deep pixel delay line plus the incoming pixel forms the two line buffers and 3x3 window.
module sigma_filter_stream #(
    parameter int DW = 10,
    parameter int W  = 128,
    parameter int H  = 128
) (
    input  logic                 sys_clk,
    input  logic                 sys_nrst,
    sigma_filter_stream_if.slave strm,
    output logic                 fsm_state
);
    localparam int N  = W * H;
    localparam int IW = $clog2(N + 1);
    localparam int FW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);
    localparam int CW = $clog2(W + 1);
    localparam int SD = 2 * W + 2;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   in_cnt;
    logic [FW-1:0]   fl_cnt;
    logic [RW-1:0]   out_r;
    logic [CW-1:0]   out_c;
    logic [DW-1:0]   thr_q;
    logic            byp_q;
    logic [DW-1:0]   sr [0:SD-1];
    logic [DW-1:0]   tap [0:8];
    logic [DW+3:0]   sum;
    logic [DW+4:0]   rnd;
    logic [DW-1:0]   out_px;
    logic            accept, emit, shift;

    assign accept = strm.data_valid & strm.data_ready;
    assign shift  = accept | (state == ST_FLUSH);
    assign emit   = (accept && (in_cnt >= IW'(W + 1))) || (state == ST_FLUSH);

    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) state <= ST_RUN;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:   if (accept && in_cnt == IW'(N - 1)) state_nx = ST_FLUSH;
            ST_FLUSH: if (fl_cnt == FW'(W))               state_nx = ST_RUN;
            default:  state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        strm.data_ready = (state == ST_RUN) && sys_nrst;
        fsm_state       = state;
    end

    // During FLUSH the line keeps shifting; the clamps guarantee the filler is never selected.
    always_ff @(posedge sys_clk) begin
        if (shift) begin
            sr[0] <= strm.data;
            for (int i = 1; i < SD; i++) sr[i] <= sr[i-1];
        end
    end

    // Tap offset into {data, sr}: centre sits W+1 back; rows step by W, columns by 1, clamped.
    always_comb begin
        int ro;
        int co;
        int idx;
        ro = 0;
        co = 0;
        idx = 0;
        for (int t = 0; t < 9; t++) begin
            if (t < 3)      ro = (out_r == '0) ? W + 1 : 2 * W + 1;
            else if (t < 6) ro = W + 1;
            else            ro = (out_r == RW'(H - 1)) ? W + 1 : 1;
            if (t % 3 == 0)      co = (out_c == '0) ? 0 : 1;
            else if (t % 3 == 1) co = 0;
            else                 co = (out_c == CW'(W - 1)) ? 0 : -1;
            idx = ro + co;
            tap[t] = (idx == 0) ? strm.data : sr[idx-1];
        end
    end

    always_comb begin
        logic [DW-1:0] d;
        logic [DW-1:0] sel;
        sum = '0;
        d   = '0;
        sel = '0;
        for (int t = 0; t < 9; t++) begin
            d   = (tap[t] > tap[4]) ? tap[t] - tap[4] : tap[4] - tap[t];
            sel = (d <= thr_q) ? tap[t] : tap[4];
            sum = sum + ({4'b0000, sel} << ((t == 4) ? 2 : (t % 2)));
        end
        rnd    = {1'b0, sum} + (DW + 5)'(8);
        out_px = byp_q ? tap[4] : rnd[DW+3:4];
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            in_cnt                   <= '0;
            fl_cnt                   <= '0;
            out_r                    <= '0;
            out_c                    <= '0;
            thr_q                    <= '0;
            byp_q                    <= 1'b0;
            strm.denoised_data       <= '0;
            strm.denoised_data_valid <= 1'b0;
            strm.denoised_sof        <= 1'b0;
            strm.denoised_eol        <= 1'b0;
        end else begin
            if (accept) begin
                in_cnt <= (in_cnt == IW'(N - 1)) ? '0 : in_cnt + 1'b1;
                if (in_cnt == '0) begin
                    thr_q <= strm.cfg_thr;
                    byp_q <= strm.cfg_bypass;
                end
            end
            if (state == ST_FLUSH) fl_cnt <= (fl_cnt == FW'(W)) ? '0 : fl_cnt + 1'b1;
            if (emit) begin
                strm.denoised_data <= out_px;
                if (out_c == CW'(W - 1)) begin
                    out_c <= '0;
                    out_r <= (out_r == RW'(H - 1)) ? '0 : out_r + 1'b1;
                end else begin
                    out_c <= out_c + 1'b1;
                end
            end
            strm.denoised_data_valid <= emit;
            strm.denoised_sof        <= emit && (out_r == '0) && (out_c == '0);
            strm.denoised_eol        <= emit && (out_c == CW'(W - 1));
        end
    end
endmodule

// File: tb/tb_sigma_filter_stream.sv
// Directed bench for sigma_filter_stream: 8x4 and 8x6 instances, hand-computed expected pixels.
module tb_sigma_filter_stream;
    localparam int DW = 10;

    logic sys_clk = 1'b0;
    logic sys_nrst = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic st_a, st_b;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    sigma_filter_stream_if #(.DW(DW)) ia ();
    sigma_filter_stream_if #(.DW(DW)) ib ();

    sigma_filter_stream #(.DW(DW), .W(8), .H(4)) dut_a (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .strm(ia), .fsm_state(st_a));
    sigma_filter_stream #(.DW(DW), .W(8), .H(6)) dut_b (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .strm(ib), .fsm_state(st_b));

    logic [DW-1:0] frame [0:63];
    int            acc_cyc [0:63];
    logic [DW-1:0] oa_d[$];
    logic          oa_sof[$];
    logic          oa_eol[$];
    int            oa_cyc[$];
    logic [DW-1:0] ob_d[$];

    always @(negedge sys_clk) begin
        if (ia.denoised_data_valid === 1'b1) begin
            oa_d.push_back(ia.denoised_data);
            oa_sof.push_back(ia.denoised_sof);
            oa_eol.push_back(ia.denoised_eol);
            oa_cyc.push_back(cyc);
        end
        if (ib.denoised_data_valid === 1'b1) ob_d.push_back(ib.denoised_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        oa_d.delete(); oa_sof.delete(); oa_eol.delete(); oa_cyc.delete(); ob_d.delete();
    endtask

    task automatic send_a(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(negedge sys_clk);
            ia.data = frame[i];
            ia.data_valid = 1'b1;
            while (ia.data_ready !== 1'b1 && w < 100) begin @(negedge sys_clk); w++; end
            if (w >= 100) begin
                total_cnt++;
                $display("FAIL send_a_ready px %0d ready=%b required 1", i, ia.data_ready);
                ia.data_valid = 1'b0;
                return;
            end
            acc_cyc[i] = cyc;
            @(posedge sys_clk);
            if (gap) begin @(negedge sys_clk); ia.data_valid = 1'b0; end
        end
        @(negedge sys_clk);
        ia.data_valid = 1'b0;
    endtask

    task automatic send_b(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(negedge sys_clk);
            ib.data = frame[i];
            ib.data_valid = 1'b1;
            while (ib.data_ready !== 1'b1 && w < 100) begin @(negedge sys_clk); w++; end
            if (w >= 100) begin
                total_cnt++;
                $display("FAIL send_b_ready px %0d ready=%b required 1", i, ib.data_ready);
                ib.data_valid = 1'b0;
                return;
            end
            @(posedge sys_clk);
        end
        @(negedge sys_clk);
        ib.data_valid = 1'b0;
    endtask

    task automatic wait_a(input int n);
        int w = 0;
        while (oa_d.size() < n && w < 300) begin @(negedge sys_clk); w++; end
        repeat (6) @(negedge sys_clk);
        total_cnt++;
        if (oa_d.size() !== n) $display("FAIL out_count_a got %0d required %0d", oa_d.size(), n);
        else pass_cnt++;
    endtask

    task automatic wait_b(input int n);
        int w = 0;
        while (ob_d.size() < n && w < 300) begin @(negedge sys_clk); w++; end
        repeat (6) @(negedge sys_clk);
        total_cnt++;
        if (ob_d.size() !== n) $display("FAIL out_count_b got %0d required %0d", ob_d.size(), n);
        else pass_cnt++;
    endtask

    task automatic check_flat_a(input string nm);
        for (int i = 0; i < 32 && i < oa_d.size(); i++) begin
            total_cnt++;
            if (oa_d[i] !== 10'd512 || oa_sof[i] !== (i == 0) || oa_eol[i] !== (i % 8 == 7))
                $display("FAIL %s out %0d got d=%0d sof=%b eol=%b required d=512 sof=%b eol=%b",
                         nm, i, oa_d[i], oa_sof[i], oa_eol[i], (i == 0), (i % 8 == 7));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        ia.data = '0; ia.data_valid = 1'b0; ia.cfg_thr = '0; ia.cfg_bypass = 1'b0;
        ib.data = '0; ib.data_valid = 1'b0; ib.cfg_thr = '0; ib.cfg_bypass = 1'b0;
        sys_nrst = 1'b0;
        repeat (3) @(negedge sys_clk);
        total_cnt++; if (ia.data_ready !== 1'b0) $display("FAIL rst_ready got %b required 0", ia.data_ready); else pass_cnt++;
        total_cnt++; if (ia.denoised_data_valid !== 1'b0) $display("FAIL rst_valid got %b required 0", ia.denoised_data_valid); else pass_cnt++;
        total_cnt++; if (ia.denoised_data !== 10'd0) $display("FAIL rst_data got %0d required 0", ia.denoised_data); else pass_cnt++;
        total_cnt++; if ({ia.denoised_sof, ia.denoised_eol} !== 2'b00) $display("FAIL rst_flags got %b required 00", {ia.denoised_sof, ia.denoised_eol}); else pass_cnt++;
        total_cnt++; if (st_a !== 1'b0) $display("FAIL rst_state got %b required 0", st_a); else pass_cnt++;
        sys_nrst = 1'b1;
        @(negedge sys_clk);
        total_cnt++; if (ia.data_ready !== 1'b1) $display("FAIL post_rst_ready got %b required 1", ia.data_ready); else pass_cnt++;
    endtask

    task automatic test_flat();
        ia.cfg_thr = 10'd0; ia.cfg_bypass = 1'b0;
        for (int i = 0; i < 32; i++) frame[i] = 10'd512;
        clear_q();
        send_a(32, 1'b0);
        wait_a(32);
        check_flat_a("flat");
    endtask

    task automatic test_latency();
        int low = 0;
        int a9, a31;
        ia.cfg_thr = 10'd5; ia.cfg_bypass = 1'b0;
        for (int i = 0; i < 32; i++) frame[i] = 10'd512;
        clear_q();
        send_a(32, 1'b0);
        a9 = acc_cyc[9];
        a31 = acc_cyc[31];
        while (ia.data_ready === 1'b0 && low < 100) begin low++; @(negedge sys_clk); end
        total_cnt++; if (low !== 9) $display("FAIL flush_len got %0d required 9", low); else pass_cnt++;
        wait_a(32);
        if (oa_cyc.size() == 32) begin
            total_cnt++; if (oa_cyc[0] !== a9 + 1) $display("FAIL first_out_cyc got %0d required %0d", oa_cyc[0], a9 + 1); else pass_cnt++;
            total_cnt++; if (oa_cyc[22] !== a31 + 1) $display("FAIL out22_cyc got %0d required %0d", oa_cyc[22], a31 + 1); else pass_cnt++;
            total_cnt++; if (oa_cyc[31] !== a31 + 10) $display("FAIL last_out_cyc got %0d required %0d", oa_cyc[31], a31 + 10); else pass_cnt++;
        end
    endtask

    task automatic test_point();
        logic [DW-1:0] exp_v [0:5];
        exp_v = '{10'd1023, 10'd0, 10'd0, 10'd256, 10'd128, 10'd64};
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 48; i++) frame[i] = 10'd0;
            frame[2*8+3] = 10'd1023;
            ib.cfg_thr = (pass == 0) ? 10'd100 : 10'd1023;
            ib.cfg_bypass = 1'b0;
            clear_q();
            send_b(48);
            wait_b(48);
            if (ob_d.size() == 48) begin
                total_cnt++; if (ob_d[19] !== exp_v[pass*3]) $display("FAIL point%0d_c23 got %0d required %0d", pass, ob_d[19], exp_v[pass*3]); else pass_cnt++;
                total_cnt++; if (ob_d[18] !== exp_v[pass*3+1]) $display("FAIL point%0d_c22 got %0d required %0d", pass, ob_d[18], exp_v[pass*3+1]); else pass_cnt++;
                total_cnt++; if (ob_d[10] !== exp_v[pass*3+2]) $display("FAIL point%0d_c12 got %0d required %0d", pass, ob_d[10], exp_v[pass*3+2]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_corner();
        for (int i = 0; i < 32; i++) frame[i] = 10'd0;
        frame[0] = 10'd160;
        ia.cfg_thr = 10'd1023; ia.cfg_bypass = 1'b0;
        clear_q();
        send_a(32, 1'b0);
        wait_a(32);
        if (oa_d.size() == 32) begin
            total_cnt++; if (oa_d[0] !== 10'd90) $display("FAIL corner_00 got %0d required 90", oa_d[0]); else pass_cnt++;
            total_cnt++; if (oa_d[1] !== 10'd30) $display("FAIL corner_01 got %0d required 30", oa_d[1]); else pass_cnt++;
            total_cnt++; if (oa_d[8] !== 10'd30) $display("FAIL corner_10 got %0d required 30", oa_d[8]); else pass_cnt++;
            total_cnt++; if (oa_d[9] !== 10'd10) $display("FAIL corner_11 got %0d required 10", oa_d[9]); else pass_cnt++;
            total_cnt++; if (oa_d[31] !== 10'd0) $display("FAIL corner_last got %0d required 0", oa_d[31]); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int a31;
        ia.cfg_thr = 10'd0; ia.cfg_bypass = 1'b1;
        for (int i = 0; i < 32; i++) frame[i] = 10'(i);
        clear_q();
        send_a(32, 1'b1);
        a31 = acc_cyc[31];
        send_a(32, 1'b1);
        total_cnt++; if (acc_cyc[0] - a31 !== 10) $display("FAIL b2b_gap got %0d required 10", acc_cyc[0] - a31); else pass_cnt++;
        wait_a(64);
        for (int i = 0; i < 64 && i < oa_d.size(); i++) begin
            total_cnt++;
            if (oa_d[i] !== 10'(i % 32) || oa_sof[i] !== (i % 32 == 0))
                $display("FAIL bypass out %0d got d=%0d sof=%b required d=%0d sof=%b",
                         i, oa_d[i], oa_sof[i], i % 32, (i % 32 == 0));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        ia.cfg_thr = 10'd1023; ia.cfg_bypass = 1'b0;
        for (int i = 0; i < 32; i++) frame[i] = 10'(i * 7);
        clear_q();
        send_a(21, 1'b0);
        sys_nrst = 1'b0;
        @(negedge sys_clk);
        total_cnt++; if (ia.denoised_data_valid !== 1'b0) $display("FAIL midrst_valid got %b required 0", ia.denoised_data_valid); else pass_cnt++;
        sys_nrst = 1'b1;
        clear_q();
        repeat (12) @(negedge sys_clk);
        total_cnt++; if (oa_d.size() !== 0) $display("FAIL midrst_stale got %0d outputs required 0", oa_d.size()); else pass_cnt++;
        for (int i = 0; i < 32; i++) frame[i] = 10'd512;
        send_a(32, 1'b0);
        wait_a(32);
        check_flat_a("after_rst");
    endtask

    initial begin
        test_reset();
        test_flat();
        test_latency();
        test_point();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
